// File: rtl/kpg_pkg.sv
// Shared definitions for the KPG adder pipeline.
//   kpg_t    : 2-bit kill/propagate/generate code for one bit position.
//   KPG_*    : the three legal codes; 2'b10 is never produced.
//   W        : operand width, fixed to the carry network width.
package kpg_pkg;

    localparam int W = 64;

    typedef logic [1:0] kpg_t;

    localparam kpg_t KPG_KILL = 2'b00;
    localparam kpg_t KPG_PROP = 2'b01;
    localparam kpg_t KPG_GEN  = 2'b11;

endpackage

// File: rtl/kpg_adder_pipe_if.sv
// Bundle of all non-clock signals of kpg_adder_pipe.
//   Input beat  : in_valid, in_ready, a, b, cin, sub
//   Carry loop  : kpg_o, cin_o (to network), carry_i (from network)
//   Result beat : out_valid, out_ready, sum, cout, ovf, zero
// Modports:
//   slave  - the adder pipeline itself
//   master - the environment (producer, consumer and carry network)
interface kpg_adder_pipe_if;
    import kpg_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic              cin;
    logic              sub;

    kpg_t [W-1:0]      kpg_o;
    logic              cin_o;
    logic [W:0]        carry_i;

    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      sum;
    logic              cout;
    logic              ovf;
    logic              zero;

    modport slave (
        input  in_valid, a, b, cin, sub, carry_i, out_ready,
        output in_ready, kpg_o, cin_o, out_valid, sum, cout, ovf, zero
    );

    modport master (
        output in_valid, a, b, cin, sub, carry_i, out_ready,
        input  in_ready, kpg_o, cin_o, out_valid, sum, cout, ovf, zero
    );

endinterface

// File: rtl/kpg_encode.sv
// Combinational KPG encoder.
//   a, b    : operands
//   sub     : 1 inverts b before encoding (subtract)
//   kpg     : per-bit kill/propagate/generate codes of a and b'
//   p       : per-bit half-sum a ^ b'
//   b_sign  : sign bit of b'
module kpg_encode
    import kpg_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output kpg_t [W-1:0] kpg,
    output logic [W-1:0] p,
    output logic         b_sign
);

    logic [W-1:0] b_eff;

    assign b_eff  = b ^ {W{sub}};
    assign p      = a ^ b_eff;
    assign b_sign = b_eff[W-1];

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        kpg = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i] & b_eff[i])
                kpg[i] = KPG_GEN;
            else if (a[i] | b_eff[i])
                kpg[i] = KPG_PROP;
            else
                kpg[i] = KPG_KILL;
        end
    end

endmodule

// File: rtl/kpg_adder_pipe.sv
// Two-stage pipelined 64-bit add/subtract around an external parallel-prefix
// carry network.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : kpg_adder_pipe_if.slave
//          stage 1 registers the KPG codes and carry-in presented to the
//          network (kpg_o, cin_o); stage 2 captures carry_i and forms
//          sum, cout, ovf and zero. Valid/ready on both ends, one op/cycle.
module kpg_adder_pipe
    import kpg_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    kpg_adder_pipe_if.slave    bus
);

    kpg_t [W-1:0] enc_kpg;
    logic [W-1:0] enc_p;
    logic         enc_b_sign;

    logic         s1_valid;
    logic         s2_valid;
    logic [W-1:0] p_q;
    logic         a_sign;
    logic         b_sign;

    logic         s1_load;
    logic         s2_load;
    logic [W-1:0] sum_next;

    kpg_encode u_encode (
        .a      (bus.a),
        .b      (bus.b),
        .sub    (bus.sub),
        .kpg    (enc_kpg),
        .p      (enc_p),
        .b_sign (enc_b_sign)
    );

    // s1 may accept whenever it is empty or is about to move into s2.
    assign s2_load      = s1_valid && (!s2_valid || bus.out_ready);
    assign bus.in_ready = !s1_valid || !s2_valid || bus.out_ready;
    assign s1_load      = bus.in_ready && bus.in_valid;

    // The network answers within the same cycle kpg_o is presented.
    assign sum_next = p_q ^ bus.carry_i[W-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    // NOTE: all pipeline registers, data included, take the async reset so
    // kpg_o and the result flags come up at defined values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            bus.kpg_o <= '0;
            bus.cin_o <= 1'b0;
            p_q       <= '0;
            a_sign    <= 1'b0;
            b_sign    <= 1'b0;
        end else if (s1_load) begin
            s1_valid  <= 1'b1;
            bus.kpg_o <= enc_kpg;
            bus.cin_o <= bus.sub | bus.cin;
            p_q       <= enc_p;
            a_sign    <= bus.a[W-1];
            b_sign    <= enc_b_sign;
        end else if (s2_load) begin
            s1_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
            bus.zero <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            bus.sum  <= sum_next;
            bus.cout <= bus.carry_i[W];
            bus.ovf  <= bus.carry_i[W] ^ bus.carry_i[W-1];
            bus.zero <= ~|sum_next;
        end else if (bus.out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign bus.out_valid = s2_valid;

    // Carry-based overflow must agree with the sign-based definition; a
    // disagreement means the external network returned inconsistent carries.
    ovf_matches_signs: assert property (@(posedge clk) disable iff (rst)
        s2_load |-> ((bus.carry_i[W] ^ bus.carry_i[W-1]) ==
                     ((a_sign == b_sign) && (sum_next[W-1] != a_sign))));

endmodule
